aoc2_range_sched: RTL and testbench

//  Sequences the shared count_combs engine over a stream of [lo,hi] ID ranges.

---
 rtl/aoc2_range_sched_pkg.sv | 22 ++
 rtl/aoc2_range_sched_if.sv | 15 +
 rtl/aoc2_range_sched_timer.sv | 28 ++
 rtl/aoc2_range_sched.sv | 169 ++++++++++++++++
 tb/tb_aoc2_range_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aoc2_range_sched_pkg.sv
// Shared types for the range-sum pipeline (parser, scheduler, count_combs engine).
package aoc2_pkg;

    localparam int DATA_WIDTH = 64;

    typedef enum logic [2:0] {
        RS_IDLE,
        RS_RST_HI,
        RS_RUN_HI,
        RS_RST_LO,
        RS_RUN_LO,
        RS_ACC,
        RS_DONE
    } rs_state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] lo;
        logic [DATA_WIDTH-1:0] hi;
        logic                  last;
    } rng_t;

endpackage

// File: rtl/aoc2_range_sched_if.sv
// Range beat channel from the parser (master) into the scheduler (slave).
interface aoc2_range_sched_if #(
    parameter int DW = aoc2_pkg::DATA_WIDTH
) ();

    logic          rng_valid;
    logic          rng_ready;
    logic [DW-1:0] rng_lo;
    logic [DW-1:0] rng_hi;
    logic          rng_last;

    modport master (output rng_valid, rng_lo, rng_hi, rng_last, input rng_ready);
    modport slave  (input rng_valid, rng_lo, rng_hi, rng_last, output rng_ready);

endinterface

// File: rtl/aoc2_range_sched_timer.sv
// Generic down-counter: load wins over enable, expired while the count is zero.
module aoc2_run_timer #(
    parameter int WIDTH = 12
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/aoc2_range_sched.sv
// Sequences the count_combs engine over [lo,hi] ranges: runs it at hi and at lo-1,
// accumulating the difference into a running total.
module aoc2_range_sched #(
    parameter int DATA_WIDTH  = aoc2_pkg::DATA_WIDTH,
    parameter int ENG_RST_CYC = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clock,
    input  logic                  reset_n,
    aoc2_range_sched_if.slave     rng,
    output logic                  eng_reset,
    output logic [DATA_WIDTH-1:0] eng_n_in,
    input  logic                  eng_count_valid,
    input  logic [DATA_WIDTH-1:0] eng_count,
    output logic [DATA_WIDTH-1:0] total_sum,
    output logic                  sum_valid,
    output logic                  err_order,
    output logic                  err_timeout
);

    import aoc2_pkg::*;

    localparam int TMAX = (ENG_RST_CYC > TIMEOUT_CYC) ? ENG_RST_CYC : TIMEOUT_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]         RST_LOAD = TW'(ENG_RST_CYC - 1);
    localparam logic [TW-1:0]         RUN_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

    rs_state_t             state;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic                  last_q;
    logic [DATA_WIDTH-1:0] c_hi;
    logic [DATA_WIDTH-1:0] c_lo;

    logic                  accept;
    logic                  run_end;
    logic [DATA_WIDTH-1:0] eng_result;
    logic                  tmr_load;
    logic                  tmr_en;
    logic [TW-1:0]         tmr_val;
    logic                  tmr_expired;

    assign rng.rng_ready = ready_q;
    assign accept        = ready_q & rng.rng_valid;
    // A run ends on a valid result or when the watchdog runs out; a timed-out run counts as 0.
    assign run_end       = eng_count_valid | tmr_expired;
    assign eng_result    = eng_count_valid ? eng_count : '0;

    // One timer serves both the reset hold and the run watchdog; it is reloaded on every phase entry.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = RST_LOAD;
        case (state)
            RS_IDLE, RS_DONE: tmr_load = accept;
            RS_RST_HI, RS_RST_LO: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = RUN_LOAD;
                end
            end
            RS_RUN_HI: begin
                tmr_en   = 1'b1;
                tmr_load = run_end;
            end
            RS_RUN_LO: tmr_en = 1'b1;
            default: ;
        endcase
    end

    aoc2_run_timer #(.WIDTH(TW)) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RS_IDLE;
            ready_q     <= 1'b0;
            eng_reset   <= 1'b1;
            eng_n_in    <= '0;
            total_sum   <= '0;
            sum_valid   <= 1'b0;
            err_order   <= 1'b0;
            err_timeout <= 1'b0;
            lo_q        <= '0;
            last_q      <= 1'b0;
            c_hi        <= '0;
            c_lo        <= '0;
        end else begin
            case (state)
                RS_IDLE, RS_DONE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        lo_q    <= rng.rng_lo;
                        last_q  <= rng.rng_last;
                        c_hi    <= '0;
                        c_lo    <= '0;
                        if (sum_valid) begin
                            sum_valid <= 1'b0;
                            total_sum <= '0;
                        end
                        if (rng.rng_lo > rng.rng_hi) begin
                            err_order <= 1'b1;
                            state     <= RS_ACC;
                        end else begin
                            eng_n_in <= rng.rng_hi;
                            state    <= RS_RST_HI;
                        end
                    end
                end
                RS_RST_HI: begin
                    if (tmr_expired) begin
                        eng_reset <= 1'b0;
                        state     <= RS_RUN_HI;
                    end
                end
                RS_RUN_HI: begin
                    if (run_end) begin
                        c_hi      <= eng_result;
                        eng_reset <= 1'b1;
                        if (!eng_count_valid) err_timeout <= 1'b1;
                        // The lower run is skipped when lo==0: nothing lies below it.
                        if (lo_q == '0) begin
                            state <= RS_ACC;
                        end else begin
                            eng_n_in <= lo_q - ONE;
                            state    <= RS_RST_LO;
                        end
                    end
                end
                RS_RST_LO: begin
                    if (tmr_expired) begin
                        eng_reset <= 1'b0;
                        state     <= RS_RUN_LO;
                    end
                end
                RS_RUN_LO: begin
                    if (run_end) begin
                        c_lo      <= eng_result;
                        eng_reset <= 1'b1;
                        if (!eng_count_valid) err_timeout <= 1'b1;
                        state <= RS_ACC;
                    end
                end
                RS_ACC: begin
                    total_sum <= total_sum + (c_hi - c_lo);
                    ready_q   <= 1'b1;
                    if (last_q) begin
                        sum_valid <= 1'b1;
                        state     <= RS_DONE;
                    end else begin
                        state <= RS_IDLE;
                    end
                end
                default: state <= RS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aoc2_range_sched.sv
// Scoreboard bench for aoc2_range_sched with a behavioural count_combs engine (L=5).
module tb_aoc2_range_sched;

    import aoc2_pkg::*;

    localparam int DW  = 64;
    localparam int RC  = 2;
    localparam int TO  = 16;
    localparam int LAT = 5;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          eng_reset;
    logic [DW-1:0] eng_n_in;
    logic          eng_count_valid;
    logic [DW-1:0] eng_count;
    logic [DW-1:0] total_sum;
    logic          sum_valid;
    logic          err_order;
    logic          err_timeout;

    aoc2_range_sched_if #(.DW(DW)) rng_if ();

    aoc2_range_sched #(
        .DATA_WIDTH  (DW),
        .ENG_RST_CYC (RC),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .rng             (rng_if),
        .eng_reset       (eng_reset),
        .eng_n_in        (eng_n_in),
        .eng_count_valid (eng_count_valid),
        .eng_count       (eng_count),
        .total_sum       (total_sum),
        .sum_valid       (sum_valid),
        .err_order       (err_order),
        .err_timeout     (err_timeout)
    );

    always #5 clock = ~clock;

    // Sum of IDs <= n that are some digit string repeated twice (11, 22, ..., 1010, ...).
    function automatic logic [63:0] sum_invalid(input logic [63:0] n);
        logic [63:0] acc;
        logic [63:0] p;
        logic [63:0] id;
        acc = '0;
        for (logic [63:0] h = 64'd1; h < 64'd100000; h++) begin
            p = 64'd10;
            while (p <= h) p = p * 64'd10;
            id = h * p + h;
            if (id > n) break;
            acc += id;
        end
        return acc;
    endfunction

    function automatic logic [63:0] range_value(input logic [63:0] lo, input logic [63:0] hi);
        if (lo > hi) return '0;
        if (lo == '0) return sum_invalid(hi);
        return sum_invalid(hi) - sum_invalid(lo - 64'd1);
    endfunction

    // Behavioural engine: result valid LAT cycles after eng_reset goes low, unless stuck.
    int unsigned eng_cnt = 0;
    bit          eng_stuck = 1'b0;
    always @(posedge clock) begin
        if (eng_reset) eng_cnt <= 0;
        else           eng_cnt <= eng_cnt + 1;
    end
    assign eng_count_valid = !eng_reset && !eng_stuck && (eng_cnt >= LAT - 1);
    assign eng_count       = eng_count_valid ? sum_invalid(eng_n_in) : 64'hdead_beef_dead_beef;

    // Scoreboard queues: expectations pushed by the driver, observations by the monitor.
    logic [63:0] n_q[$];
    logic [63:0] sum_q[$];
    logic [63:0] obs_n_q[$];
    logic [63:0] obs_sum_q[$];
    int unsigned obs_cyc_q[$];
    logic [63:0] job_sum = '0;

    int unsigned cyc = 0;
    int unsigned accept_cyc = 0;
    int unsigned done_cyc = 0;
    int unsigned ready_viol = 0;
    int unsigned run_viol = 0;
    bit          prev_eng_reset = 1'b1;
    bit          prev_sum_valid = 1'b0;
    logic [63:0] prev_n = '0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset_n) begin
            if (prev_eng_reset && !eng_reset) obs_n_q.push_back(eng_n_in);
            if (!prev_eng_reset && !eng_reset && (eng_n_in !== prev_n)) run_viol <= run_viol + 1;
            if (!prev_sum_valid && sum_valid) begin
                obs_sum_q.push_back(total_sum);
                obs_cyc_q.push_back(cyc);
            end
            if (rng_if.rng_ready && !eng_reset) ready_viol <= ready_viol + 1;
        end
        prev_eng_reset <= eng_reset;
        prev_sum_valid <= sum_valid;
        prev_n         <= eng_n_in;
    end

    task automatic send_range(input logic [63:0] lo, input logic [63:0] hi,
                              input bit last, input bit hold);
        bit ok;
        if (lo <= hi) begin
            n_q.push_back(hi);
            if (lo != '0) n_q.push_back(lo - 64'd1);
        end
        job_sum += range_value(lo, hi);
        if (last) begin
            sum_q.push_back(job_sum);
            job_sum = '0;
        end
        @(negedge clock);
        rng_if.rng_valid = 1'b1;
        rng_if.rng_lo    = lo;
        rng_if.rng_hi    = hi;
        rng_if.rng_last  = last;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (rng_if.rng_ready) begin
                @(posedge clock);
                #1;
                accept_cyc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL handshake [%0d,%0d]: rng_ready never seen, required within 4000 cycles", lo, hi);
        end
        if (!hold) begin
            @(negedge clock);
            rng_if.rng_valid = 1'b0;
        end
    endtask

    task automatic check_scoreboard(input string name);
        logic [63:0] exp_v;
        logic [63:0] got_v;
        int w = 0;
        while ((obs_sum_q.size() == 0) && (w < 3000)) begin
            @(negedge clock);
            w++;
        end
        exp_v = sum_q.pop_front();
        checks++;
        if (obs_sum_q.size() == 0) begin
            errors++;
            $display("FAIL %s total_sum: sum_valid never rose, required total %0d", name, exp_v);
        end else begin
            got_v    = obs_sum_q.pop_front();
            done_cyc = obs_cyc_q.pop_front();
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s total_sum: got %0d expected %0d", name, got_v, exp_v);
            end
        end
        while (n_q.size() > 0) begin
            exp_v = n_q.pop_front();
            checks++;
            if (obs_n_q.size() == 0) begin
                errors++;
                $display("FAIL %s eng_n_in: engine run missing, expected n=%0d", name, exp_v);
            end else begin
                got_v = obs_n_q.pop_front();
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL %s eng_n_in: got %0d expected %0d", name, got_v, exp_v);
                end
            end
        end
        checks++;
        if (obs_n_q.size() != 0) begin
            errors++;
            $display("FAIL %s engine runs: got %0d extra runs expected 0", name, obs_n_q.size());
            obs_n_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({rng_if.rng_ready, eng_reset, sum_valid, err_order, err_timeout} !== 5'b01000 ||
            eng_n_in !== '0 || total_sum !== '0) begin
            errors++;
            $display("FAIL reset_values: ready/eng_reset/sum_valid/err_order/err_timeout=%b n=%0d sum=%0d expected 01000 0 0",
                     {rng_if.rng_ready, eng_reset, sum_valid, err_order, err_timeout}, eng_n_in, total_sum);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (rng_if.rng_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b expected 0", rng_if.rng_ready);
        end
        @(negedge clock);
        checks++;
        if (rng_if.rng_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got %b expected 1", rng_if.rng_ready);
        end
    endtask

    task automatic test_single();
        logic [63:0] held;
        send_range(64'd11, 64'd22, 1'b1, 1'b0);
        check_scoreboard("single");
        checks++;
        if ((done_cyc - accept_cyc) != 2 * (RC + LAT) + 1) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d", done_cyc - accept_cyc, 2 * (RC + LAT) + 1);
        end
        held = total_sum;
        repeat (4) @(negedge clock);
        checks++;
        if ({sum_valid, rng_if.rng_ready, err_order} !== 3'b110 || total_sum !== held) begin
            errors++;
            $display("FAIL done_hold: sum_valid/ready/err_order=%b sum=%0d expected 110 sum=%0d",
                     {sum_valid, rng_if.rng_ready, err_order}, total_sum, held);
        end
    endtask

    task automatic test_lo_zero();
        send_range(64'd0, 64'd99, 1'b1, 1'b0);
        checks++;
        if (sum_valid !== 1'b0 || total_sum !== '0) begin
            errors++;
            $display("FAIL restart_on_accept: sum_valid=%b sum=%0d expected 0 0", sum_valid, total_sum);
        end
        check_scoreboard("lo_zero");
        checks++;
        if (err_order !== 1'b0) begin
            errors++;
            $display("FAIL lo_zero err_order: got %b expected 0", err_order);
        end
    endtask

    task automatic test_lo_eq_hi();
        send_range(64'd22, 64'd22, 1'b1, 1'b0);
        check_scoreboard("lo_eq_hi");
    endtask

    task automatic test_order();
        send_range(64'd50, 64'd20, 1'b0, 1'b0);
        checks++;
        if (err_order !== 1'b1) begin
            errors++;
            $display("FAIL err_order: got %b expected 1", err_order);
        end
        send_range(64'd998, 64'd1012, 1'b1, 1'b0);
        check_scoreboard("order");
    endtask

    task automatic test_back_to_back();
        rng_t        beats[5];
        int unsigned rv0;
        int unsigned sv0;
        beats[0] = '{lo: 64'd5,    hi: 64'd30,   last: 1'b0};
        beats[1] = '{lo: 64'd100,  hi: 64'd200,  last: 1'b0};
        beats[2] = '{lo: 64'd1000, hi: 64'd1111, last: 1'b0};
        beats[3] = '{lo: 64'd22,   hi: 64'd22,   last: 1'b0};
        beats[4] = '{lo: 64'd11,   hi: 64'd22,   last: 1'b1};
        rv0 = ready_viol;
        sv0 = run_viol;
        foreach (beats[i]) send_range(beats[i].lo, beats[i].hi, beats[i].last, i < 4);
        check_scoreboard("back_to_back");
        checks++;
        if (ready_viol != rv0) begin
            errors++;
            $display("FAIL ready_while_running: got %0d cycles expected 0", ready_viol - rv0);
        end
        checks++;
        if (run_viol != sv0) begin
            errors++;
            $display("FAIL n_in_stable: got %0d changes during runs expected 0", run_viol - sv0);
        end
    endtask

    task automatic test_timeout();
        int w = 0;
        eng_stuck = 1'b1;
        send_range(64'd11, 64'd22, 1'b1, 1'b0);
        sum_q.pop_back();
        sum_q.push_back(64'd0);
        while (eng_reset && (w < 100)) begin
            @(negedge clock);
            w++;
        end
        repeat (TO - 1) @(negedge clock);
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got %b after %0d run cycles expected 0", err_timeout, TO - 1);
        end
        @(negedge clock);
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: got %b after %0d run cycles expected 1", err_timeout, TO);
        end
        check_scoreboard("timeout");
        eng_stuck = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int w = 0;
        send_range(64'd11, 64'd22, 1'b1, 1'b0);
        while (eng_reset && (w < 100)) begin
            @(negedge clock);
            w++;
        end
        repeat (2) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rng_if.rng_ready, eng_reset, sum_valid, err_order, err_timeout} !== 5'b01000 ||
            eng_n_in !== '0 || total_sum !== '0) begin
            errors++;
            $display("FAIL async_clear: ready/eng_reset/sum_valid/err_order/err_timeout=%b n=%0d sum=%0d expected 01000 0 0",
                     {rng_if.rng_ready, eng_reset, sum_valid, err_order, err_timeout}, eng_n_in, total_sum);
        end
        n_q.delete();
        sum_q.delete();
        obs_n_q.delete();
        obs_sum_q.delete();
        obs_cyc_q.delete();
        job_sum = '0;
        @(negedge clock);
        reset_n = 1'b1;
        send_range(64'd11, 64'd22, 1'b1, 1'b0);
        check_scoreboard("after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded 500000 time units");
        $fatal(1);
    end

    initial begin
        rng_if.rng_valid = 1'b0;
        rng_if.rng_lo    = '0;
        rng_if.rng_hi    = '0;
        rng_if.rng_last  = 1'b0;
        test_reset();
        test_single();
        test_lo_zero();
        test_lo_eq_hi();
        test_order();
        test_back_to_back();
        test_timeout();
        test_reset_mid_run();
        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
